// File: rtl/kf8237_transfer_timing_control.sv
// KF8237 transfer sequencer: DREQ arbitration, HRQ/HLDA handshake, the
// SI/S0..S4 transfer state machine and the bus strobes. Drives the
// address/count register file (select, next_word, initialize) and consumes
// its current address, underflow and high-address-change flags.
module kf8237_transfer_timing_control (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  dma_request,
    input  logic        hold_acknowledge,
    input  logic        ready,
    input  logic [3:0]  request_mask,
    input  logic        controller_disable,
    input  logic        rotating_priority,
    input  logic [7:0]  transfer_mode_config,
    input  logic [7:0]  transfer_type_config,
    input  logic [3:0]  autoinitialize_config,
    input  logic [15:0] transfer_address,
    input  logic        underflow,
    input  logic        update_high_address,
    output logic [3:0]  transfer_register_select,
    output logic        next_word,
    output logic        initialize_current_register,
    output logic        hold_request,
    output logic [3:0]  dma_acknowledge,
    output logic        address_enable,
    output logic        address_strobe,
    output logic [7:0]  output_address,
    output logic [7:0]  output_high_address,
    output logic        io_read,
    output logic        io_write,
    output logic        memory_read,
    output logic        memory_write,
    output logic        end_of_process,
    output logic [3:0]  terminal_count
);

    typedef enum logic [2:0] {
        STATE_SI,
        STATE_S0,
        STATE_S1,
        STATE_S2,
        STATE_S3,
        STATE_S4
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [3:0]  select_reg;
    logic [1:0]  channel_reg;
    logic [1:0]  lowest_reg;
    logic        mode_block_reg;
    logic        mode_demand_reg;
    logic        type_write_reg;
    logic        type_read_reg;
    logic        autoinit_reg;
    logic [7:0]  high_address_reg;

    logic [3:0]  candidate;
    logic [1:0]  search_base;
    logic [1:0]  probe;
    logic [1:0]  winner_index;
    logic        winner_found;
    logic [1:0]  winner_mode;
    logic [1:0]  winner_type;
    logic        channel_active;

    // A channel competes only when requesting, unmasked and the controller is enabled.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_candidate
            assign candidate[gi] = dma_request[gi] & ~request_mask[gi] & ~controller_disable;
        end
    endgenerate

    // Priority search: fixed starts at channel 0, rotating starts just past the last serviced channel.
    always_comb begin
        search_base  = rotating_priority ? (lowest_reg + 2'd1) : 2'd0;
        winner_found = 1'b0;
        winner_index = 2'd0;
        probe        = 2'd0;
        for (int k = 0; k < 4; k++) begin
            probe = search_base + 2'(k);
            if (!winner_found && candidate[probe]) begin
                winner_found = 1'b1;
                winner_index = probe;
            end
        end
    end

    assign winner_mode    = transfer_mode_config[{winner_index, 1'b0} +: 2];
    assign winner_type    = transfer_type_config[{winner_index, 1'b0} +: 2];
    assign channel_active = dma_request[channel_reg] & ~request_mask[channel_reg];

    // Next-state logic for the transfer sequence.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            STATE_SI: if (winner_found) state_next = STATE_S0;
            STATE_S0: begin
                if (!channel_active)       state_next = STATE_SI;
                else if (hold_acknowledge) state_next = STATE_S1;
            end
            STATE_S1: state_next = STATE_S2;
            STATE_S2: state_next = STATE_S3;
            STATE_S3: if (ready) state_next = STATE_S4;
            STATE_S4: begin
                // Single mode (and the 11 encoding) always ends after one word.
                if (underflow || !(mode_block_reg || mode_demand_reg))
                    state_next = STATE_SI;
                else if (mode_block_reg || channel_active)
                    state_next = update_high_address ? STATE_S1 : STATE_S2;
                else
                    state_next = STATE_SI;
            end
            default: state_next = STATE_SI;
        endcase
    end

    // State register plus per-transfer latches (channel, mode, type, rotation pointer, high address).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg        <= STATE_SI;
            select_reg       <= 4'd0;
            channel_reg      <= 2'd0;
            lowest_reg       <= 2'd3;
            mode_block_reg   <= 1'b0;
            mode_demand_reg  <= 1'b0;
            type_write_reg   <= 1'b0;
            type_read_reg    <= 1'b0;
            autoinit_reg     <= 1'b0;
            high_address_reg <= 8'd0;
        end else begin
            state_reg <= state_next;
            if (state_reg == STATE_SI && state_next == STATE_S0) begin
                select_reg      <= 4'b0001 << winner_index;
                channel_reg     <= winner_index;
                mode_block_reg  <= (winner_mode == 2'b10);
                mode_demand_reg <= (winner_mode == 2'b00);
                type_write_reg  <= (winner_type == 2'b01);
                type_read_reg   <= (winner_type == 2'b10);
                autoinit_reg    <= autoinitialize_config[winner_index];
            end else if (state_reg != STATE_SI && state_next == STATE_SI) begin
                select_reg <= 4'd0;
            end
            // A channel counts as serviced once HLDA lets it onto the bus.
            if (state_reg == STATE_S0 && state_next == STATE_S1)
                lowest_reg <= channel_reg;
            if (state_reg == STATE_S1)
                high_address_reg <= transfer_address[15:8];
        end
    end

    // Bus strobes and register-file controls decoded from the current state.
    always_comb begin
        transfer_register_select    = select_reg;
        next_word                   = 1'b0;
        initialize_current_register = 1'b0;
        hold_request                = 1'b0;
        dma_acknowledge             = 4'd0;
        address_enable              = 1'b0;
        address_strobe              = 1'b0;
        output_address              = 8'd0;
        output_high_address         = high_address_reg;
        io_read                     = 1'b0;
        io_write                    = 1'b0;
        memory_read                 = 1'b0;
        memory_write                = 1'b0;
        end_of_process              = 1'b0;
        terminal_count              = 4'd0;
        case (state_reg)
            STATE_S0: hold_request = 1'b1;
            STATE_S1: begin
                hold_request        = 1'b1;
                address_enable      = 1'b1;
                address_strobe      = 1'b1;
                dma_acknowledge     = select_reg;
                output_address      = transfer_address[7:0];
                output_high_address = transfer_address[15:8];
            end
            STATE_S2: begin
                hold_request    = 1'b1;
                address_enable  = 1'b1;
                dma_acknowledge = select_reg;
                output_address  = transfer_address[7:0];
                io_read         = type_write_reg;
                memory_read     = type_read_reg;
            end
            STATE_S3: begin
                hold_request    = 1'b1;
                address_enable  = 1'b1;
                dma_acknowledge = select_reg;
                output_address  = transfer_address[7:0];
                io_read         = type_write_reg;
                memory_read     = type_read_reg;
                memory_write    = type_write_reg;
                io_write        = type_read_reg;
            end
            STATE_S4: begin
                hold_request                = 1'b1;
                address_enable              = 1'b1;
                dma_acknowledge             = select_reg;
                output_address              = transfer_address[7:0];
                next_word                   = 1'b1;
                end_of_process              = underflow;
                terminal_count              = select_reg & {4{underflow}};
                initialize_current_register = underflow & autoinit_reg;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_kf8237_transfer_timing_control.sv
// Bench for the KF8237 transfer sequencer. A small address/count register
// file model answers the DUT; every S4 word is captured and checked against
// expected words queued when each request is raised.
module tb_kf8237_transfer_timing_control;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  dma_request;
    logic        hold_acknowledge;
    logic        ready;
    logic [3:0]  request_mask;
    logic        controller_disable;
    logic        rotating_priority;
    logic [7:0]  transfer_mode_config;
    logic [7:0]  transfer_type_config;
    logic [3:0]  autoinitialize_config;
    logic [15:0] transfer_address;
    logic        underflow;
    logic        update_high_address;
    logic [3:0]  transfer_register_select;
    logic        next_word;
    logic        initialize_current_register;
    logic        hold_request;
    logic [3:0]  dma_acknowledge;
    logic        address_enable;
    logic        address_strobe;
    logic [7:0]  output_address;
    logic [7:0]  output_high_address;
    logic        io_read;
    logic        io_write;
    logic        memory_read;
    logic        memory_write;
    logic        end_of_process;
    logic [3:0]  terminal_count;

    kf8237_transfer_timing_control dut (
        .clock                       (clock),
        .reset                       (reset),
        .dma_request                 (dma_request),
        .hold_acknowledge            (hold_acknowledge),
        .ready                       (ready),
        .request_mask                (request_mask),
        .controller_disable          (controller_disable),
        .rotating_priority           (rotating_priority),
        .transfer_mode_config        (transfer_mode_config),
        .transfer_type_config        (transfer_type_config),
        .autoinitialize_config       (autoinitialize_config),
        .transfer_address            (transfer_address),
        .underflow                   (underflow),
        .update_high_address         (update_high_address),
        .transfer_register_select    (transfer_register_select),
        .next_word                   (next_word),
        .initialize_current_register (initialize_current_register),
        .hold_request                (hold_request),
        .dma_acknowledge             (dma_acknowledge),
        .address_enable              (address_enable),
        .address_strobe              (address_strobe),
        .output_address              (output_address),
        .output_high_address         (output_high_address),
        .io_read                     (io_read),
        .io_write                    (io_write),
        .memory_read                 (memory_read),
        .memory_write                (memory_write),
        .end_of_process              (end_of_process),
        .terminal_count              (terminal_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]  sel;
        logic [15:0] addr;
        logic        eop;
        logic [3:0]  tc;
        logic        init;
        logic        s1;
    } word_t;

    word_t exp_q[$];
    word_t obs_q[$];
    int    checks = 0;
    int    errors = 0;

    logic [15:0] cfg_addr [4];
    logic [15:0] cfg_count[4];
    logic [3:0]  cfg_load;
    logic [15:0] cur_addr [4];
    logic [15:0] cur_count[4];
    logic [1:0]  sel_idx;
    logic        sel_valid;
    logic        auto_hlda;
    logic        seen_s1 = 1'b0;
    logic [37:0] all_outputs;
    logic [3:0]  strobes;

    assign all_outputs = {transfer_register_select, next_word, initialize_current_register,
                          hold_request, dma_acknowledge, address_enable, address_strobe,
                          output_address, output_high_address, io_read, io_write,
                          memory_read, memory_write, end_of_process, terminal_count};
    assign strobes = {io_read, io_write, memory_read, memory_write};

    // Register file model: current address/count of the selected channel.
    always_comb begin
        sel_valid = 1'b1;
        sel_idx   = 2'd0;
        case (transfer_register_select)
            4'b0001: sel_idx = 2'd0;
            4'b0010: sel_idx = 2'd1;
            4'b0100: sel_idx = 2'd2;
            4'b1000: sel_idx = 2'd3;
            default: sel_valid = 1'b0;
        endcase
        transfer_address    = sel_valid ? cur_addr[sel_idx] : 16'h0000;
        underflow           = next_word && sel_valid && (cur_count[sel_idx] == 16'h0000);
        update_high_address = next_word && sel_valid && (cur_addr[sel_idx][7:0] == 8'hFF);
    end

    always @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (cfg_load[i]) begin
                cur_addr[i]  <= cfg_addr[i];
                cur_count[i] <= cfg_count[i];
            end
        end
        if (next_word && sel_valid) begin
            if (initialize_current_register) begin
                cur_addr[sel_idx]  <= cfg_addr[sel_idx];
                cur_count[sel_idx] <= cfg_count[sel_idx];
            end else begin
                cur_addr[sel_idx]  <= cur_addr[sel_idx] + 16'd1;
                cur_count[sel_idx] <= cur_count[sel_idx] - 16'd1;
            end
        end
    end

    // CPU side: grant HLDA one half-cycle after HRQ when enabled.
    always @(negedge clock) hold_acknowledge = auto_hlda & hold_request;

    // Capture every S4 word, noting whether an address strobe preceded it.
    always @(negedge clock) begin
        word_t w;
        if (address_strobe) seen_s1 = 1'b1;
        if (next_word) begin
            w.sel  = transfer_register_select;
            w.addr = {output_high_address, output_address};
            w.eop  = end_of_process;
            w.tc   = terminal_count;
            w.init = initialize_current_register;
            w.s1   = seen_s1;
            obs_q.push_back(w);
            seen_s1 = 1'b0;
        end
    end

    function automatic word_t make_word(input logic [3:0] sel, input logic [15:0] addr,
                                        input logic eop, input logic init, input logic s1);
        word_t w;
        w.sel  = sel;
        w.addr = addr;
        w.eop  = eop;
        w.tc   = eop ? sel : 4'd0;
        w.init = init;
        w.s1   = s1;
        return w;
    endfunction

    task automatic load_channel(input int ch, input logic [15:0] addr, input logic [15:0] count);
        cfg_addr[ch]  = addr;
        cfg_count[ch] = count;
        cfg_load[ch]  = 1'b1;
        @(negedge clock);
        cfg_load[ch]  = 1'b0;
    endtask

    task automatic set_channel(input int ch, input logic [1:0] mode, input logic [1:0] ttype,
                               input logic autoinit);
        transfer_mode_config[2*ch +: 2] = mode;
        transfer_type_config[2*ch +: 2] = ttype;
        autoinitialize_config[ch]       = autoinit;
    endtask

    task automatic wait_hrq(input string name, output int n);
        n = 0;
        while (hold_request !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (hold_request !== 1'b1) begin
            errors++;
            $display("FAIL %s_hrq_timeout: hold_request=%b required 1", name, hold_request);
        end
    endtask

    task automatic wait_adstb(input string name, output int n);
        n = 0;
        while (address_strobe !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (address_strobe !== 1'b1) begin
            errors++;
            $display("FAIL %s_adstb_timeout: address_strobe=%b required 1", name, address_strobe);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((hold_request !== 1'b0 || transfer_register_select !== 4'd0) && n < 100) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (hold_request !== 1'b0 || transfer_register_select !== 4'd0) begin
            errors++;
            $display("FAIL %s_idle_timeout: hrq=%b sel=%b required 0/0000",
                     name, hold_request, transfer_register_select);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        checks++;
        if (all_outputs !== 38'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", all_outputs);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (all_outputs !== 38'd0) begin
            errors++;
            $display("FAIL idle_outputs: got %h required 0", all_outputs);
        end
    endtask

    task automatic test_single_transfer();
        int n;
        word_t e, o;
        set_channel(1, 2'b01, 2'b01, 1'b0);
        load_channel(1, 16'h1234, 16'h0002);
        exp_q.push_back(make_word(4'b0010, 16'h1234, 1'b0, 1'b0, 1'b1));
        dma_request[1] = 1'b1;
        wait_hrq("single", n);
        checks++;
        if (n != 1 || transfer_register_select !== 4'b0010) begin
            errors++;
            $display("FAIL single_hrq: latency=%0d sel=%b required 1/0010", n, transfer_register_select);
        end
        wait_adstb("single", n);
        checks++;
        if (n != 1 || output_high_address !== 8'h12 || output_address !== 8'h34 || address_enable !== 1'b1) begin
            errors++;
            $display("FAIL single_s1: latency=%0d hi=%h lo=%h aen=%b required 1/12/34/1",
                     n, output_high_address, output_address, address_enable);
        end
        @(negedge clock);
        checks++;
        if (strobes !== 4'b1000 || dma_acknowledge !== 4'b0010) begin
            errors++;
            $display("FAIL single_s2: strobes=%b dack=%b required 1000/0010", strobes, dma_acknowledge);
        end
        @(negedge clock);
        checks++;
        if (strobes !== 4'b1001) begin
            errors++;
            $display("FAIL single_s3: strobes=%b required 1001", strobes);
        end
        @(negedge clock);
        checks++;
        if (next_word !== 1'b1 || strobes !== 4'b0000) begin
            errors++;
            $display("FAIL single_s4: next_word=%b strobes=%b required 1/0000", next_word, strobes);
        end
        @(negedge clock);
        checks++;
        if (hold_request !== 1'b0 || transfer_register_select !== 4'd0) begin
            errors++;
            $display("FAIL single_si: hrq=%b sel=%b required 0/0000", hold_request, transfer_register_select);
        end
        exp_q.push_back(make_word(4'b0010, 16'h1235, 1'b0, 1'b0, 1'b1));
        wait_adstb("single2", n);
        dma_request[1] = 1'b0;
        wait_idle("single2");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL single_word: missing, required %h", e);
            end else begin
                o = obs_q.pop_front();
                $display("single word sel=%b addr=%h eop=%b tc=%b init=%b s1=%b", o.sel, o.addr, o.eop, o.tc, o.init, o.s1);
                if (o !== e) begin
                    errors++;
                    $display("FAIL single_word: got %h required %h", o, e);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL single_extra: got %0d extra words required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_block_terminal_count();
        int n;
        word_t e, o;
        set_channel(0, 2'b10, 2'b10, 1'b1);
        load_channel(0, 16'h4000, 16'h0001);
        exp_q.push_back(make_word(4'b0001, 16'h4000, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(make_word(4'b0001, 16'h4001, 1'b1, 1'b1, 1'b0));
        dma_request[0] = 1'b1;
        wait_adstb("block", n);
        dma_request[0] = 1'b0;
        @(negedge clock);
        checks++;
        if (strobes !== 4'b0010) begin
            errors++;
            $display("FAIL block_s2: strobes=%b required 0010", strobes);
        end
        @(negedge clock);
        checks++;
        if (strobes !== 4'b0110) begin
            errors++;
            $display("FAIL block_s3: strobes=%b required 0110", strobes);
        end
        wait_idle("block");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL block_word: missing, required %h", e);
            end else begin
                o = obs_q.pop_front();
                $display("block word sel=%b addr=%h eop=%b tc=%b init=%b s1=%b", o.sel, o.addr, o.eop, o.tc, o.init, o.s1);
                if (o !== e) begin
                    errors++;
                    $display("FAIL block_word: got %h required %h", o, e);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL block_extra: got %0d extra words required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_high_address_skip();
        int n;
        word_t e, o;
        logic [15:0] a;
        set_channel(2, 2'b10, 2'b01, 1'b0);
        load_channel(2, 16'h00FE, 16'h0003);
        for (int k = 0; k < 4; k++) begin
            a = 16'h00FE + 16'(k);
            exp_q.push_back(make_word(4'b0100, a, (k == 3), 1'b0, (k == 0) || (a[7:0] == 8'h00)));
        end
        dma_request[2] = 1'b1;
        wait_adstb("highaddr", n);
        dma_request[2] = 1'b0;
        wait_idle("highaddr");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL highaddr_word: missing, required %h", e);
            end else begin
                o = obs_q.pop_front();
                $display("highaddr word sel=%b addr=%h eop=%b tc=%b init=%b s1=%b", o.sel, o.addr, o.eop, o.tc, o.init, o.s1);
                if (o !== e) begin
                    errors++;
                    $display("FAIL highaddr_word: got %h required %h", o, e);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL highaddr_extra: got %0d extra words required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_priority();
        int n;
        word_t e, o;
        logic [3:0] want_sel [4];
        logic [3:0] drop_req [4];
        set_channel(0, 2'b01, 2'b00, 1'b0);
        set_channel(2, 2'b01, 2'b00, 1'b0);
        load_channel(0, 16'h5000, 16'h0010);
        load_channel(2, 16'h6000, 16'h0010);
        // Fixed priority with ch0 and ch2 both requesting: ch0 then ch2.
        rotating_priority = 1'b0;
        exp_q.push_back(make_word(4'b0001, 16'h5000, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(make_word(4'b0100, 16'h6000, 1'b0, 1'b0, 1'b1));
        dma_request = 4'b0101;
        want_sel[0] = 4'b0001; drop_req[0] = 4'b0100;
        want_sel[1] = 4'b0100; drop_req[1] = 4'b0000;
        for (int t = 0; t < 2; t++) begin
            wait_hrq("prio_fixed", n);
            checks++;
            if (transfer_register_select !== want_sel[t]) begin
                errors++;
                $display("FAIL prio_fixed_sel%0d: got %b required %b", t, transfer_register_select, want_sel[t]);
            end
            wait_adstb("prio_fixed", n);
            dma_request = drop_req[t];
            wait_idle("prio_fixed");
        end
        // Rotating: service ch0 alone so it becomes lowest, then ch0+ch2 picks ch2 first.
        rotating_priority = 1'b1;
        exp_q.push_back(make_word(4'b0001, 16'h5001, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(make_word(4'b0100, 16'h6001, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(make_word(4'b0001, 16'h5002, 1'b0, 1'b0, 1'b1));
        dma_request = 4'b0001;
        wait_hrq("prio_rot", n);
        wait_adstb("prio_rot", n);
        dma_request = 4'b0000;
        wait_idle("prio_rot");
        dma_request = 4'b0101;
        want_sel[0] = 4'b0100; drop_req[0] = 4'b0001;
        want_sel[1] = 4'b0001; drop_req[1] = 4'b0000;
        for (int t = 0; t < 2; t++) begin
            wait_hrq("prio_rot", n);
            checks++;
            if (transfer_register_select !== want_sel[t]) begin
                errors++;
                $display("FAIL prio_rot_sel%0d: got %b required %b", t, transfer_register_select, want_sel[t]);
            end
            wait_adstb("prio_rot", n);
            dma_request = drop_req[t];
            wait_idle("prio_rot");
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL prio_word: missing, required %h", e);
            end else begin
                o = obs_q.pop_front();
                $display("prio word sel=%b addr=%h eop=%b tc=%b init=%b s1=%b", o.sel, o.addr, o.eop, o.tc, o.init, o.s1);
                if (o !== e) begin
                    errors++;
                    $display("FAIL prio_word: got %h required %h", o, e);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL prio_extra: got %0d extra words required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_ready_waits();
        int n;
        word_t e, o;
        // ch1 continues from 0x1236 with count 0: this word is its terminal count.
        exp_q.push_back(make_word(4'b0010, 16'h1236, 1'b1, 1'b0, 1'b1));
        dma_request[1] = 1'b1;
        wait_adstb("ready", n);
        dma_request[1] = 1'b0;
        @(negedge clock);
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++;
            if (strobes !== 4'b1001 || next_word !== 1'b0) begin
                errors++;
                $display("FAIL ready_s3_%0d: strobes=%b next_word=%b required 1001/0", i, strobes, next_word);
            end
            if (i == 3) ready = 1'b1;
        end
        @(negedge clock);
        checks++;
        if (next_word !== 1'b1) begin
            errors++;
            $display("FAIL ready_s4: next_word=%b required 1", next_word);
        end
        wait_idle("ready");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL ready_word: missing, required %h", e);
            end else begin
                o = obs_q.pop_front();
                $display("ready word sel=%b addr=%h eop=%b tc=%b init=%b s1=%b", o.sel, o.addr, o.eop, o.tc, o.init, o.s1);
                if (o !== e) begin
                    errors++;
                    $display("FAIL ready_word: got %h required %h", o, e);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL ready_extra: got %0d extra words required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_abort_and_reset();
        int n;
        word_t e, o;
        // Request dropped while waiting for HLDA.
        set_channel(3, 2'b01, 2'b00, 1'b0);
        auto_hlda = 1'b0;
        dma_request[3] = 1'b1;
        wait_hrq("abort", n);
        checks++;
        if (transfer_register_select !== 4'b1000) begin
            errors++;
            $display("FAIL abort_sel: got %b required 1000", transfer_register_select);
        end
        dma_request[3] = 1'b0;
        @(negedge clock);
        checks++;
        if (hold_request !== 1'b0 || transfer_register_select !== 4'd0) begin
            errors++;
            $display("FAIL abort_si: hrq=%b sel=%b required 0/0000", hold_request, transfer_register_select);
        end
        auto_hlda = 1'b1;
        // Reset asserted in S3 clears everything without waiting for a clock.
        load_channel(1, 16'h7000, 16'h0005);
        dma_request[1] = 1'b1;
        wait_adstb("reset", n);
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (memory_write !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_s3: memory_write=%b required 1", memory_write);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (all_outputs !== 38'd0) begin
            errors++;
            $display("FAIL reset_async: got %h required 0", all_outputs);
        end
        dma_request[1] = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        exp_q.push_back(make_word(4'b0010, 16'h7000, 1'b0, 1'b0, 1'b1));
        dma_request[1] = 1'b1;
        wait_hrq("restart", n);
        checks++;
        if (n != 1 || transfer_register_select !== 4'b0010) begin
            errors++;
            $display("FAIL restart_hrq: latency=%0d sel=%b required 1/0010", n, transfer_register_select);
        end
        wait_adstb("restart", n);
        dma_request[1] = 1'b0;
        wait_idle("restart");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL restart_word: missing, required %h", e);
            end else begin
                o = obs_q.pop_front();
                $display("restart word sel=%b addr=%h eop=%b tc=%b init=%b s1=%b", o.sel, o.addr, o.eop, o.tc, o.init, o.s1);
                if (o !== e) begin
                    errors++;
                    $display("FAIL restart_word: got %h required %h", o, e);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL restart_extra: got %0d extra words required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    initial begin
        reset                 = 1'b1;
        dma_request           = 4'd0;
        ready                 = 1'b1;
        request_mask          = 4'd0;
        controller_disable    = 1'b0;
        rotating_priority     = 1'b0;
        transfer_mode_config  = 8'd0;
        transfer_type_config  = 8'd0;
        autoinitialize_config = 4'd0;
        cfg_load              = 4'd0;
        auto_hlda             = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cfg_addr[i]  = 16'd0;
            cfg_count[i] = 16'd0;
        end
        test_reset();
        test_single_transfer();
        test_block_terminal_count();
        test_high_address_skip();
        test_priority();
        test_ready_waits();
        test_abort_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kf8237_transfer_timing_control.md
# kf8237_transfer_timing_control

Transfer sequencer for the KF8237 DMA controller. It arbitrates the four DREQ lines and runs the hold handshake with the CPU. It steps the S0–S4 transfer state machine and drives the bus strobes. It is the driving side of the address/count register file: it issues `transfer_register_select`, `next_word` and `initialize_current_register`, and consumes `transfer_address`, `underflow` and `update_high_address`.

## Interface
Parameters: none.

- `clock` in 1: single clock. All state here updates on the rising edge. The register file samples this block's outputs on the following falling edge.
- `reset` in 1: asynchronous, active-high.
- `dma_request` in 4: DREQ per channel. Already synchronized, active-high.
- `hold_acknowledge` in 1: HLDA from CPU.
- `ready` in 1: wait-state input, sampled in S3.
- `request_mask` in 4: masked channels are ignored.
- `controller_disable` in 1: blocks new arbitration.
- `rotating_priority` in 1: 0 = fixed priority, channel 0 highest.
- `transfer_mode_config` in 8: 2 bits per channel. 00 demand, 01 single, 10 block, 11 treated as single.
- `transfer_type_config` in 8: 2 bits per channel. 00 verify, 01 write (IO→mem), 10 read (mem→IO), 11 treated as verify.
- `autoinitialize_config` in 4: autoinit enable per channel.
- `transfer_address` in 16: current address of the selected channel.
- `underflow` in 1: word count wraps on this `next_word`.
- `update_high_address` in 1: high address byte changes on this `next_word`.
- `transfer_register_select` out 4: one-hot active channel. 0 when idle.
- `next_word` out 1: advance address/count.
- `initialize_current_register` out 1: reload current registers from base.
- `hold_request` out 1: HRQ.
- `dma_acknowledge` out 4: DACK, one-hot.
- `address_enable` out 1: AEN.
- `address_strobe` out 1: ADSTB.
- `output_address` out 8: A7–A0.
- `output_high_address` out 8: byte placed on the data bus during ADSTB.
- `io_read`, `io_write`, `memory_read`, `memory_write` out 1 each: active-high internal strobes.
- `end_of_process` out 1: EOP pulse.
- `terminal_count` out 4: one-cycle TC pulse per channel, for the status register.

## Operation
- **States:** SI, S0, S1, S2, S3, S4. One state per clock except waits.
- **SI:**
  - Find candidates: unmasked channels with an active request, only when `controller_disable`=0.
  - Choose the winner by priority and latch it as one-hot `transfer_register_select`.
  - Latch that channel's mode, type and autoinit; then go to S0.
- **Priority:**
  - Fixed: channel 0 is highest.
  - Rotating: the last serviced channel becomes lowest. The rotation pointer resets to channel 3 as lowest.
- **S0:**
  - `hold_request`=1.
  - Wait for `hold_acknowledge`=1, then go to S1.
  - If the selected channel's request drops or it becomes masked before HLDA, return to SI and clear the select.
- **S1:**
  - `address_enable`=1 and `address_strobe`=1.
  - `output_high_address` = `transfer_address[15:8]`, held until the next S1.
- **S2:**
  - `dma_acknowledge[ch]`=1.
  - Assert the read strobe: `io_read` for write type, `memory_read` for read type. Verify type drives no strobe.
- **S3:**
  - Assert the write strobe: `memory_write` for write type, `io_write` for read type. The read strobe stays on.
  - If `ready`=0, stay in S3.
- **S4:**
  - Strobes are off and `next_word`=1 for this one cycle.
  - If `underflow`=1: `end_of_process`=1, `terminal_count[ch]`=1, and `initialize_current_register`=1 if autoinit is set (the register file gives initialize priority).
- **After S4, next state:**
  - TC, or single mode: SI.
  - Block mode, or demand mode with the request still active: S1 if `update_high_address`=1, else S2.
  - Demand mode with the request dropped: SI.
- **Outputs outside the transfer states:**
  - `address_enable` and `dma_acknowledge` stay held from S1 through S4 and are 0 in SI/S0.
  - `output_address` = `transfer_address[7:0]` in S1–S4, else 0.
- **Request changes:** a request drop after S0 does not abort single or block transfers.

## Timing
- Every output resets to 0 and the state resets to SI.
- `reset` mid-transfer drops all strobes, HRQ and DACK immediately (asynchronously).
- Request to HRQ: one clock (the SI→S0 edge).
- HLDA to ADSTB: one clock.
- Single transfer with `ready`=1: S1,S2,S3,S4 = 4 clocks. Each `ready`=0 sample in S3 adds one clock.
- `next_word`, `end_of_process`, `terminal_count` and `initialize_current_register` are each exactly one clock wide, in S4 only.
- `underflow` and `update_high_address` are combinational functions of `next_word`. They are valid only in S4 and ignored elsewhere.
- HRQ deasserts on the clock leaving S4 to SI.

## Test plan
- **Single transfer:** ch1 single/write, count=0x0002, DREQ1 held. Expect HRQ; HLDA returns S1; S1 ADSTB with the high byte; `io_read` in S2; `io_read`+`memory_write` in S3. Expect one `next_word`, then SI with HRQ low. A second request gives a second cycle.
- **Block with terminal count:** ch0 block/read, count=0x0001. Expect exactly two S4 cycles; the second has EOP and `terminal_count`=0001; then SI. With autoinit=1, `initialize_current_register` pulses alongside.
- **High-address skip:** block mode, address 0x00FE increment. Expect S1 only on the first word and on the 0x00FF→0x0100 crossing; other words go S4→S2.
- **Priority:** DREQ0 and DREQ2 simultaneous. Fixed priority services ch0 first. Rotating priority with ch0 last serviced selects ch2.
- **Ready waits:** `ready`=0 for 3 clocks in S3. Expect S3 held 4 clocks with strobes steady and `next_word` after.
- **Abort and reset:** DREQ drop in S0 returns to SI. `reset` asserted in S3 zeroes all outputs immediately, and the next arbitration starts cleanly.
